imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage's instruction-address port. It accepts one word-aligned fetch address at a time, returns the 32-bit instruction after a fixed latency, and raises `busy` so the fetch stage holds its PC and pipeline register. A load port fills the array before or during execution. A `flush` aborts an in-flight fetch on a taken branch.

## Interface
- `ADDR_BITS`, default 10: array depth is 2^ADDR_BITS words.
- `LATENCY`, default 2: cycles from the accept edge to the `instr_valid` edge. Legal range is 1..15.
- `BASE`, default 32'h00000000: byte address of word 0.
- `CLK`, in, 1: clock. All state changes on the rising edge.
- `RESET`, in, 1: asynchronous, active-low.
- `req_valid`, in, 1: fetch request present.
- `req_addr`, in, 32: fetch byte address. Driven by the fetch stage's instruction-address output.
- `flush`, in, 1: abort the in-flight request (taken branch).
- `busy`, out, 1: request outstanding. The fetch stage treats it as "no new fetch".
- `instr_valid`, out, 1: one-cycle pulse; `instr_out` and `fault` are valid.
- `instr_out`, out, 32: fetched instruction.
- `fault`, out, 1: the fetched address was misaligned or out of range.
- `load_en`, in, 1: write strobe for the array.
- `load_addr`, in, 32: byte address of the write.
- `load_data`, in, 32: write data.

## Operation
- FSM states are IDLE, WAIT and RESP.
- `busy` = (state == WAIT).
- `instr_valid` = (state == RESP).
- Accept condition: `req_valid` && (state == IDLE || state == RESP). On accept:
  - Latch `req_addr`.
  - Load the down-counter `cnt` with LATENCY-1.
  - If LATENCY == 1, go directly to RESP and capture data on the same edge. Otherwise go to WAIT.
- WAIT: `cnt` decrements each cycle. On the edge where `cnt` == 1:
  - Capture the array word into `instr_out`.
  - Go to RESP.
- RESP lasts one cycle:
  - No new accept: go to IDLE.
  - Accept: follow the accept rules above (back-to-back).
- Fault check, applied to the latched address `a`:
  - Fault if `a[1:0]` != 0.
  - Fault if (`a` - BASE) >> 2 >= 2^ADDR_BITS. Compute the subtraction in 32 bits; an address below BASE wraps to a large value and therefore faults.
  - On fault: `instr_out` = 32'h00000000 (null instruction), `fault` = 1, and the array is not read.
- `flush`:
  - In WAIT: go to IDLE. No `instr_valid` pulse is produced for the aborted request.
  - In RESP: no effect; the pulse is already out.
  - `flush` and `req_valid` in the same cycle: the abort happens first and the new request is accepted on the same edge.
- Load port:
  - A write occurs on any cycle with `load_en`, whatever the FSM state.
  - The write is dropped if `load_addr` would fault under the same check.
  - A write and a data capture to the same word on the same edge: the capture returns the old data (read-before-write).
- Array contents are not reset.

## Timing
- Reset values: state = IDLE, `busy` = 0, `instr_valid` = 0, `instr_out` = 0, `fault` = 0, `cnt` = 0.
- Latency: request accepted at edge N; `instr_valid` is high in the cycle following edge N+LATENCY-1.
- `busy` is high in cycles N+1 .. N+LATENCY-1, i.e. LATENCY-1 cycles. It is never high when LATENCY = 1.
- Throughput: one instruction per LATENCY cycles with back-to-back requests.
- `instr_out` and `fault` hold their values until the next capture.
- Reset asserted mid-request: all outputs clear immediately and the request is lost.
- `req_valid` while in WAIT is ignored. The requester must hold it or re-issue it.

## Test plan
- Preload words 0..3 with 32'h11111111, 22222222, 33333333, 44444444. LATENCY = 2, `req_addr` = 32'h4 at edge N:
  - `busy` high for 1 cycle.
  - `instr_valid` pulses in the cycle after edge N+1 with `instr_out` = 32'h22222222 and `fault` = 0.
- Back-to-back requests to 0x0, 0x4, 0x8 (LATENCY = 2), each re-issued during RESP:
  - Three `instr_valid` pulses two cycles apart.
  - Data 11111111, 22222222, 33333333.
- `req_addr` = 32'h6, then `req_addr` = (BASE + 4×2^ADDR_BITS):
  - Each gives `instr_valid` with `fault` = 1 and `instr_out` = 0.
  - Array unchanged.
- LATENCY = 3: request 0x0, then `flush` together with `req_valid` at 0xC one cycle later:
  - No pulse for 0x0.
  - A single pulse with 32'h44444444 three cycles after the second accept.
- Capture of word 1 on the same edge as a `load_en` write of 32'hDEADBEEF to 0x4:
  - Returns 22222222.
  - A following fetch of 0x4 returns DEADBEEF.
- `RESET` low in the middle of WAIT:
  - `busy`, `instr_valid`, `instr_out` and `fault` go to 0 without waiting for a clock edge.
  - No pulse after release.
  - Preloaded data is retained.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory serving a fetch port, with load port and flush.
// Ports: CLK/RESET (async active-low); i_req_valid/i_req_addr fetch request; i_flush aborts a
// waiting fetch; o_busy while waiting; o_instr_valid pulse with o_instr_out/o_fault;
// i_load_en/i_load_addr/i_load_data write the array.
module imem_responder #(
  parameter int          ADDR_BITS = 10,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE      = 32'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_instr_valid,
  output logic [31:0] o_instr_out,
  output logic        o_fault,
  input  logic        i_load_en,
  input  logic [31:0] i_load_addr,
  input  logic [31:0] i_load_data
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_addr, r_instr, w_cap_addr;
  logic        r_fault, w_accept, w_capture, w_cap_bad, w_load_bad;
  logic [29:0] w_cap_off, w_load_off;
  logic [31:0] r_mem [0:2**ADDR_BITS-1];
  always_comb begin
    // a flush in WAIT frees the port, so a same-cycle request is taken on this edge
    w_accept   = i_req_valid && (r_state != S_WAIT || i_flush);
    // with LATENCY 1 the data is captured on the accept edge straight from the request
    w_cap_addr = (LATENCY == 1) ? i_req_addr : r_addr;
    w_capture  = (w_accept && LATENCY == 1) || (r_state == S_WAIT && !i_flush && r_cnt == 4'd1);
    // word offset from BASE; addresses below BASE wrap huge and fault
    w_cap_off  = 30'((w_cap_addr - BASE) >> 2);
    w_load_off = 30'((i_load_addr - BASE) >> 2);
    w_cap_bad  = (w_cap_addr[1:0] != 2'b0) || (w_cap_off >= 30'(2**ADDR_BITS));
    w_load_bad = (i_load_addr[1:0] != 2'b0) || (w_load_off >= 30'(2**ADDR_BITS));
    w_next     = w_accept ? ((LATENCY == 1) ? S_RESP : S_WAIT)
               : (r_state == S_WAIT) ? (i_flush ? S_IDLE : (r_cnt == 4'd1) ? S_RESP : S_WAIT)
               : S_IDLE;
    w_cnt_next = w_accept ? 4'(LATENCY - 1) : (r_state == S_WAIT) ? r_cnt - 4'd1 : r_cnt;
  end
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'h0;
      r_instr <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) r_addr <= i_req_addr;
      if (w_capture) begin
        r_instr <= w_cap_bad ? 32'h0 : r_mem[w_cap_off[ADDR_BITS-1:0]];
        r_fault <= w_cap_bad;
      end
    end
  end
  // array is not reset; the nonblocking write makes a same-edge capture see the old word
  always_ff @(posedge CLK) begin
    if (i_load_en && !w_load_bad) r_mem[w_load_off[ADDR_BITS-1:0]] <= i_load_data;
  end
  assign o_busy        = (r_state == S_WAIT);
  assign o_instr_valid = (r_state == S_RESP);
  assign o_instr_out   = r_instr;
  assign o_fault       = r_fault;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed self-checking bench for imem_responder at LATENCY 2 and 3.
module tb_imem_responder;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0, flush = 1'b0, load_en = 1'b0;
  logic [31:0] req_addr = 32'h0, load_addr = 32'h0, load_data = 32'h0;
  logic        busy2, valid2, fault2, busy3, valid3, fault3;
  logic [31:0] instr2, instr3;
  int          n_cmp = 0, n_err = 0;
  always #5 CLK = ~CLK;
  imem_responder #(.LATENCY(2)) d2 (
    .CLK(CLK), .RESET(RESET), .i_req_valid(req_valid), .i_req_addr(req_addr), .i_flush(flush),
    .o_busy(busy2), .o_instr_valid(valid2), .o_instr_out(instr2), .o_fault(fault2),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data));
  imem_responder #(.LATENCY(3)) d3 (
    .CLK(CLK), .RESET(RESET), .i_req_valid(req_valid), .i_req_addr(req_addr), .i_flush(flush),
    .o_busy(busy3), .o_instr_valid(valid3), .o_instr_out(instr3), .o_fault(fault3),
    .i_load_en(load_en), .i_load_addr(load_addr), .i_load_data(load_data));
  task automatic step;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int n);
    req_valid = 1'b0;
    flush = 1'b0;
    load_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic test_reset;
    #1 RESET = 1'b0;
    #2;
    n_cmp++;
    if ({busy2, valid2, fault2, instr2, busy3, valid3, fault3, instr3} !== 70'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {busy2, valid2, fault2, instr2, busy3, valid3, fault3, instr3});
    end
    step();
    step();
    RESET = 1'b1;
    step();
    n_cmp++;
    if ({busy2, valid2, busy3, valid3} !== 4'h0) begin
      n_err++;
      $display("FAIL reset_idle: got %b want 0000", {busy2, valid2, busy3, valid3});
    end
  endtask
  task automatic preload;
    logic [31:0] w [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4; i++) begin
      load_en = 1'b1;
      load_addr = 32'(i * 4);
      load_data = w[i];
      step();
    end
    load_en = 1'b0;
  endtask
  task automatic test_single;
    req_valid = 1'b1;
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if ({busy2, valid2} !== 2'b10) begin
      n_err++;
      $display("FAIL single_busy: got busy/valid %b want 10", {busy2, valid2});
    end
    step();
    n_cmp++;
    if ({busy2, valid2, fault2, instr2} !== {3'b010, 32'h22222222}) begin
      n_err++;
      $display("FAIL single_resp: got b/v/f %b data %h want 010 22222222", {busy2, valid2, fault2}, instr2);
    end
    step();
    n_cmp++;
    if ({busy2, valid2, instr2} !== {2'b00, 32'h22222222}) begin
      n_err++;
      $display("FAIL single_hold: got b/v %b data %h want 00 22222222", {busy2, valid2}, instr2);
    end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr = 32'(i * 4);
      step();
      req_valid = 1'b0;
      n_cmp++;
      if ({busy2, valid2} !== 2'b10) begin
        n_err++;
        $display("FAIL b2b_wait%0d: got busy/valid %b want 10", i, {busy2, valid2});
      end
      step();
      n_cmp++;
      if ({valid2, fault2, instr2} !== {2'b10, w[i]}) begin
        n_err++;
        $display("FAIL b2b_resp%0d: got v/f %b data %h want 10 %h", i, {valid2, fault2}, instr2, w[i]);
      end
    end
    step();
    n_cmp++;
    if ({busy2, valid2} !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_idle: got busy/valid %b want 00", {busy2, valid2});
    end
  endtask
  task automatic test_fault;
    logic [31:0] a [4] = '{32'h6, 32'h1000, 32'h0, 32'h4};
    logic [31:0] e [4] = '{32'h0, 32'h0, 32'h11111111, 32'h22222222};
    logic        f [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    load_en = 1'b1;
    load_addr = 32'h6;
    load_data = 32'hBADBAD01;
    step();
    load_addr = 32'h1000;
    load_data = 32'hBADBAD00;
    step();
    load_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr = a[i];
      step();
      req_valid = 1'b0;
      step();
      n_cmp++;
      if ({valid2, fault2, instr2} !== {1'b1, f[i], e[i]}) begin
        n_err++;
        $display("FAIL fault_%h: got v/f %b data %h want %b %h", a[i], {valid2, fault2}, instr2, {1'b1, f[i]}, e[i]);
      end
    end
  endtask
  task automatic test_flush;
    idle(4);
    n_cmp++;
    if ({busy3, valid3} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_start_idle: got busy/valid %b want 00", {busy3, valid3});
    end
    req_valid = 1'b1;
    req_addr = 32'h0;
    step();
    req_addr = 32'hC;
    flush = 1'b1;
    n_cmp++;
    if ({busy3, valid3} !== 2'b10) begin
      n_err++;
      $display("FAIL flush_first_wait: got busy/valid %b want 10", {busy3, valid3});
    end
    step();
    req_valid = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({busy3, valid3} !== 2'b10) begin
        n_err++;
        $display("FAIL flush_wait%0d: got busy/valid %b want 10", i, {busy3, valid3});
      end
      step();
    end
    n_cmp++;
    if ({busy3, valid3, fault3, instr3} !== {3'b010, 32'h44444444}) begin
      n_err++;
      $display("FAIL flush_resp: got b/v/f %b data %h want 010 44444444", {busy3, valid3, fault3}, instr3);
    end
    step();
    n_cmp++;
    if ({busy3, valid3} !== 2'b00) begin
      n_err++;
      $display("FAIL flush_single_pulse: got busy/valid %b want 00", {busy3, valid3});
    end
    idle(3);
  endtask
  task automatic test_read_before_write;
    req_valid = 1'b1;
    req_addr = 32'h4;
    step();
    req_valid = 1'b0;
    load_en = 1'b1;
    load_addr = 32'h4;
    load_data = 32'hDEADBEEF;
    step();
    load_en = 1'b0;
    n_cmp++;
    if ({valid2, instr2} !== {1'b1, 32'h22222222}) begin
      n_err++;
      $display("FAIL rbw_old: got v %b data %h want 1 22222222", valid2, instr2);
    end
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    n_cmp++;
    if ({valid2, instr2} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rbw_new: got v %b data %h want 1 deadbeef", valid2, instr2);
    end
  endtask
  task automatic test_reset_mid;
    logic [31:0] a [2] = '{32'hC, 32'h4};
    logic [31:0] e [2] = '{32'h44444444, 32'hDEADBEEF};
    req_valid = 1'b1;
    req_addr = 32'h8;
    step();
    req_valid = 1'b0;
    n_cmp++;
    if ({busy2, instr2} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++;
      $display("FAIL rst_mid_pre: got busy %b data %h want 1 deadbeef", busy2, instr2);
    end
    #2 RESET = 1'b0;
    #1;
    n_cmp++;
    if ({busy2, valid2, fault2, instr2} !== 35'h0) begin
      n_err++;
      $display("FAIL rst_mid_async: got b/v/f %b data %h want 000 0", {busy2, valid2, fault2}, instr2);
    end
    step();
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({busy2, valid2} !== 2'b00) begin
        n_err++;
        $display("FAIL rst_mid_nopulse%0d: got busy/valid %b want 00", i, {busy2, valid2});
      end
    end
    for (int i = 0; i < 2; i++) begin
      req_valid = 1'b1;
      req_addr = a[i];
      step();
      req_valid = 1'b0;
      step();
      n_cmp++;
      if ({valid2, fault2, instr2} !== {2'b10, e[i]}) begin
        n_err++;
        $display("FAIL rst_retain_%h: got v/f %b data %h want 10 %h", a[i], {valid2, fault2}, instr2, e[i]);
      end
    end
  endtask
  initial begin
    test_reset();
    preload();
    test_single();
    idle(2);
    test_back_to_back();
    idle(2);
    test_fault();
    test_flush();
    test_read_before_write();
    idle(4);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
